// File: rtl/rr_mux_arb_stage_if.sv
// Handshake bundle between requesters, the mux tree, and the arbiter output slot.
// The arbiter drives the master side; the requester/tree/downstream model drives the slave side.
interface rr_mux_arb_stage_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  localparam int SEL_W = $clog2(N);

  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [SEL_W-1:0]   sel;
  logic [WIDTH-1:0]   mux_data;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic               out_ready;

  modport master (
    input  req_valid, mux_data, out_ready,
    output req_ready, sel, out_valid, out_data
  );

  modport slave (
    output req_valid, mux_data, out_ready,
    input  req_ready, sel, out_valid, out_data
  );
endinterface

// File: rtl/rr_mux_arb_stage.sv
// Round-robin arbiter that steers a mux tree via a binary select and
// registers the selected lane into a one-entry valid/ready output slot.
module rr_mux_arb_stage #(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  rr_mux_arb_stage_if.master  bus
);
  localparam int SEL_W = $clog2(N);

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] data;
  } slot_t;

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] last_sel;
  slot_t            slot_q;

  logic [N-1:0]     win;
  logic [SEL_W-1:0] win_idx;
  logic             any_req;
  logic             can_accept;
  logic             accept;

  assign any_req    = |bus.req_valid;
  assign can_accept = ~slot_q.vld | bus.out_ready;
  assign accept     = any_req & can_accept;

  // Each lane wins if it is valid and no valid lane sits closer to ptr in
  // circular order; distance wraps naturally because N is a power of two.
  for (genvar g = 0; g < N; g++) begin : g_lane
    localparam logic [SEL_W-1:0] IDX = SEL_W'(g);
    logic [SEL_W-1:0] dist_me;
    logic             blocked;

    assign dist_me = IDX - ptr;

    always_comb begin
      blocked = 1'b0;
      for (int j = 0; j < N; j++) begin
        if (bus.req_valid[j] && (SEL_W'(j) - ptr) < dist_me)
          blocked = 1'b1;
      end
    end

    assign win[g] = bus.req_valid[g] & ~blocked;
  end

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (win[i])
        win_idx = SEL_W'(i);
    end
  end

  // Outputs are forced quiet while reset is held so no grant leaks out.
  always_comb begin
    bus.sel       = '0;
    bus.req_ready = '0;
    if (!reset) begin
      bus.sel       = any_req ? win_idx : last_sel;
      bus.req_ready = accept ? win : '0;
    end
  end

  assign bus.out_valid = slot_q.vld;
  assign bus.out_data  = slot_q.data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr      <= '0;
      last_sel <= '0;
      slot_q   <= '0;
    end else if (accept) begin
      slot_q.vld  <= 1'b1;
      slot_q.data <= bus.mux_data;
      ptr         <= win_idx + SEL_W'(1);
      last_sel    <= win_idx;
    end else if (slot_q.vld && bus.out_ready) begin
      slot_q.vld  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_mux_arb_stage.sv
// Directed bench for rr_mux_arb_stage: reset, round robin, wrap/skip,
// backpressure, idle hold and data path, with a behavioural mux tree.
module tb_rr_mux_arb_stage;
  localparam int N     = 4;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] lanes [N];
  int               n_cmp = 0;
  int               n_err = 0;

  rr_mux_arb_stage_if #(.N(N), .WIDTH(WIDTH)) bus ();

  assign bus.mux_data = lanes[bus.sel];

  rr_mux_arb_stage #(.N(N), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic [WIDTH-1:0] l0, l1, l2, l3);
    lanes[0] = l0; lanes[1] = l1; lanes[2] = l2; lanes[3] = l3;
  endtask

  initial begin
    logic [1:0] seq [3];

    // Reset state, with a request present that must not leak through
    reset         = 1'b1;
    bus.req_valid = 4'b1000;
    bus.out_ready = 1'b1;
    set_lanes(8'hA0, 8'hB1, 8'hC2, 8'hD3);
    #1;
    chk("rst_sel",       32'(bus.sel),       32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);

    // Data path from reset: only lane 3 valid
    #1 reset = 1'b0;
    #1;
    chk("dp_sel",       32'(bus.sel),       32'd3);
    chk("dp_req_ready", 32'(bus.req_ready), 32'b1000);
    step();
    chk("dp_out_data",  32'(bus.out_data),  32'hD3);
    chk("dp_out_valid", 32'(bus.out_valid), 32'd1);

    bus.req_valid = 4'b0000;
    #1;
    chk("dp_idle_ready", 32'(bus.req_ready), 32'd0);
    chk("dp_idle_sel",   32'(bus.sel),       32'd3);
    step();
    chk("dp_drain_valid", 32'(bus.out_valid), 32'd0);
    chk("dp_drain_data",  32'(bus.out_data),  32'hD3);

    // Round robin, ptr=0 after the lane-3 grant wrapped
    set_lanes(8'h10, 8'h21, 8'h32, 8'h43);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rr%0d_sel", k),       32'(bus.sel),       32'(k % 4));
      chk($sformatf("rr%0d_req_ready", k), 32'(bus.req_ready), 32'(1 << (k % 4)));
      step();
      chk($sformatf("rr%0d_out_data", k),  32'(bus.out_data),  32'(lanes[k % 4]));
      chk($sformatf("rr%0d_out_valid", k), 32'(bus.out_valid), 32'd1);
    end

    // Move ptr to 3 by granting lane 2, then 4'b0101 must go 0,2,0
    bus.req_valid = 4'b0100;
    #1;
    chk("wrap_pre_sel", 32'(bus.sel), 32'd2);
    step();
    chk("wrap_pre_data", 32'(bus.out_data), 32'h32);
    bus.req_valid = 4'b0101;
    seq[0] = 2'd0; seq[1] = 2'd2; seq[2] = 2'd0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("wrap%0d_sel", k),       32'(bus.sel),       32'(seq[k]));
      chk($sformatf("wrap%0d_req_ready", k), 32'(bus.req_ready), 32'(1 << seq[k]));
      step();
      chk($sformatf("wrap%0d_out_data", k),  32'(bus.out_data),  32'(lanes[seq[k]]));
    end

    // Backpressure: slot holds lane 0 data, ptr=1
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0010;
    #1;
    chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
    chk("bp_sel",       32'(bus.sel),       32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("bp%0d_out_data", k),  32'(bus.out_data),  32'h10);
      chk($sformatf("bp%0d_out_valid", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp%0d_req_ready", k), 32'(bus.req_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.req_ready), 32'b0010);
    step();
    chk("bp_swap_data",  32'(bus.out_data),  32'h21);
    chk("bp_swap_valid", 32'(bus.out_valid), 32'd1);
    bus.req_valid = 4'b1111;
    #1;
    chk("bp_ptr_sel", 32'(bus.sel), 32'd2);

    // Idle: sel holds the last granted lane, slot drains
    bus.req_valid = 4'b0000;
    #1;
    chk("idle_req_ready", 32'(bus.req_ready), 32'd0);
    chk("idle_sel",       32'(bus.sel),       32'd1);
    step();
    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
    chk("idle_out_data",  32'(bus.out_data),  32'h21);
    step();
    chk("idle2_out_valid", 32'(bus.out_valid), 32'd0);
    chk("idle2_sel",       32'(bus.sel),       32'd1);
    chk("idle2_req_ready", 32'(bus.req_ready), 32'd0);

    // Re-enable into an empty slot with no downstream ready
    bus.req_valid = 4'b1111;
    bus.out_ready = 1'b0;
    #1;
    chk("reen_sel",       32'(bus.sel),       32'd2);
    chk("reen_req_ready", 32'(bus.req_ready), 32'b0100);
    step();
    chk("reen_out_data",  32'(bus.out_data),  32'h32);
    chk("reen_out_valid", 32'(bus.out_valid), 32'd1);

    // Reset mid-transfer: slot full and stalled
    #1 reset = 1'b1;
    #1;
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_out_data",  32'(bus.out_data),  32'd0);
    chk("mrst_sel",       32'(bus.sel),       32'd0);
    chk("mrst_req_ready", 32'(bus.req_ready), 32'd0);
    step();
    chk("mrst_hold_valid", 32'(bus.out_valid), 32'd0);
    #1 reset = 1'b0;
    #1;
    chk("post_rst_sel",       32'(bus.sel),       32'd0);
    chk("post_rst_req_ready", 32'(bus.req_ready), 32'b0001);
    bus.out_ready = 1'b1;
    step();
    chk("post_rst_out_data",  32'(bus.out_data),  32'h10);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
